// File: rtl/uart_mem_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mem_bridge_pkg: shared types and frame constants for the bridge |
// | Optional feature macro: UART_MEM_BRIDGE_CHECKSUM_EN                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_mem_bridge_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h57;
  localparam logic [7:0] CMD_READ      = 8'h52;
  localparam logic [7:0] RSP_ACK       = 8'h06;
  localparam logic [7:0] RSP_NAK       = 8'h15;
  localparam int         MAX_RSP_BYTES = 5;
  localparam int         RSP_W         = 8 * MAX_RSP_BYTES;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_GET_ADDR   = 4'd1,
    S_GET_DATA   = 4'd2,
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    S_GET_CSUM   = 4'd3,
`endif
    S_DO_WRITE   = 4'd4,
    S_DO_READ    = 4'd5,
    S_WAIT_RDATA = 4'd6,
    S_SEND       = 4'd7
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_SEND      = 2'd1,
    TX_SEND_LOW  = 2'd2,
    TX_SEND_HIGH = 2'd3
  } tx_state_t;

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mem_bridge_tx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_sequencer: shifts out a reply frame, byte by byte, using the |
// | tx_ready handshake; pulses done after the last byte has drained.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_sequencer
  import uart_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [RSP_W-1:0] load_bytes,
  input  logic [2:0]       load_cnt,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic             done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t        state_q, state_d;
  logic [RSP_W-1:0] shreg_q, shreg_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  // Reply bytes are stored MSB-first; the head byte is always on tx_data.
  assign tx_data = shreg_q[RSP_W-1 -: 8];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    tx_start = 1'b0;
    done     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (load) begin
          shreg_d = load_bytes;
          cnt_d   = load_cnt;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        // Gating with tx_ready keeps tx_start from ever firing into a busy UART.
        if (tx_ready) begin
          tx_start = 1'b1;
          shreg_d  = shreg_q << 8;
          cnt_d    = cnt_q - 3'd1;
          tmo_d    = '0;
          state_d  = TX_SEND_LOW;
        end
      end
      TX_SEND_LOW: begin
        if (!tx_ready || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = '0;
          state_d = TX_SEND_HIGH;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      TX_SEND_HIGH: begin
        if (tx_ready) begin
          if (cnt_q == 3'd0) begin
            done    = 1'b1;
            state_d = TX_IDLE;
          end else begin
            state_d = TX_SEND;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_mem_bridge: decodes host read/write frames from a UART into     |
// | single-word memory accesses and returns the reply frame.             |
// | Optional feature macro: UART_MEM_BRIDGE_CHECKSUM_EN (XOR checksums)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter  int ADDR_BYTES     = 2,
  parameter  int TIMEOUT_CYCLES = 50000000,
  localparam int ADDR_W         = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_cmd,
  output logic              err_overrun
);

  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);

`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  localparam state_t S_READ_NEXT  = S_GET_CSUM;
  localparam state_t S_WRITE_NEXT = S_GET_CSUM;
`else
  localparam state_t S_READ_NEXT  = S_DO_READ;
  localparam state_t S_WRITE_NEXT = S_DO_WRITE;
`endif

  state_t            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              busy_q, busy_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_cmd_q, err_cmd_d;
  logic              err_overrun_q, err_overrun_d;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              collecting;
  logic              rsp_load;
  logic [RSP_W-1:0]  rsp_bytes;
  logic [2:0]        rsp_cnt;
  logic              seq_done;

`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  assign collecting = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) ||
                      (state_q == S_GET_CSUM);
`else
  assign collecting = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
`endif

  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_timeout_d = 1'b0;
    err_cmd_d     = 1'b0;
    err_overrun_d = 1'b0;
    rsp_load      = 1'b0;
    rsp_bytes     = '0;
    rsp_cnt       = 3'd0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tmo_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            is_write_d = (rx_data == CMD_WRITE);
            state_d    = S_GET_ADDR;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
            csum_d     = rx_data;
`endif
          end else begin
            err_cmd_d = 1'b1;
            rsp_load  = 1'b1;
            rsp_bytes = {RSP_NAK, 32'h0};
            rsp_cnt   = 3'd1;
            state_d   = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d = (addr_q << 8) | ADDR_W'(rx_data);
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = is_write_q ? S_GET_DATA : S_READ_NEXT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_data};
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          if (cnt_q == 3'd3) begin
            cnt_d   = '0;
            state_d = S_WRITE_NEXT;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      S_GET_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = is_write_q ? S_DO_WRITE : S_DO_READ;
          end else begin
            err_cmd_d = 1'b1;
            rsp_load  = 1'b1;
            rsp_bytes = {RSP_NAK, 32'h0};
            rsp_cnt   = 3'd1;
            state_d   = S_SEND;
          end
        end
      end
`endif
      S_DO_WRITE: begin
        rsp_load  = 1'b1;
        rsp_bytes = {RSP_ACK, 32'h0};
        rsp_cnt   = 3'd1;
        state_d   = S_SEND;
      end
      S_DO_READ: begin
        tmo_d   = '0;
        state_d = S_WAIT_RDATA;
      end
      S_WAIT_RDATA: begin
        // mem_re is high only during DO_READ, so a same-cycle rvalid never lands here.
        if (mem_rvalid) begin
          rsp_load = 1'b1;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          rsp_bytes = {mem_rdata, xor4(mem_rdata)};
          rsp_cnt   = 3'd5;
`else
          rsp_bytes = {mem_rdata, 8'h00};
          rsp_cnt   = 3'd4;
`endif
          state_d = S_SEND;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          rsp_load      = 1'b1;
          rsp_bytes     = {RSP_NAK, 32'h0};
          rsp_cnt       = 3'd1;
          state_d       = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND: begin
        if (seq_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; an arriving byte beats a simultaneous expiry.
    if (collecting) begin
      if (rx_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        err_timeout_d = 1'b1;
        tmo_d         = '0;
        cnt_d         = '0;
        state_d       = S_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (rx_valid && !collecting && state_q != S_IDLE) err_overrun_d = 1'b1;

    mem_we_d = (state_d == S_DO_WRITE);
    mem_re_d = (state_d == S_DO_READ);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      is_write_q    <= 1'b0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_cmd_q     <= 1'b0;
      err_overrun_q <= 1'b0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      err_cmd_q     <= err_cmd_d;
      err_overrun_q <= err_overrun_d;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_cmd     = err_cmd_q;
  assign err_overrun = err_overrun_q;

  uart_tx_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tx_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (rsp_load),
    .load_bytes(rsp_bytes),
    .load_cnt  (rsp_cnt),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .done      (seq_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_mem_bridge: frame-level reference model and per-cycle checks |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_mem_bridge;

  localparam int AB  = 2;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        busy;
  logic        err_timeout;
  logic        err_cmd;
  logic        err_overrun;

  always #5 clk = ~clk;

  uart_mem_bridge #(
    .ADDR_BYTES(AB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .busy(busy), .err_timeout(err_timeout), .err_cmd(err_cmd), .err_overrun(err_overrun)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [47:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  frame[$];
  logic [31:0] ref_mem[logic [15:0]];
  logic [31:0] dut_mem[logic [15:0]];
  int exp_cmd = 0, exp_tmo = 0, exp_ovr = 0;
  int n_cmd = 0, n_tmo = 0, n_ovr = 0;
  int tx_seen = 0;
  int rlat = 3;
  logic [15:0] ra;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_default(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
  endfunction

  // UART transmitter: busy from one cycle after tx_start for 20 cycles.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk); #1 tx_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Memory: answers each mem_re after rlat cycles from its own contents.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_re) begin
        ra = mem_addr;
        repeat (rlat) @(posedge clk);
        #1 mem_rdata = dut_mem.exists(ra) ? dut_mem[ra] : mem_default(ra);
        mem_rvalid = 1'b1;
        @(posedge clk); #1 mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  // Per-cycle compare against the frame-level expectations.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        chk("tx_start_while_ready", tx_ready, 1);
        tx_seen++;
        tx_log.push_back(tx_data);
        chk("tx_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (mem_we) begin
        chk("we_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("we_addr", mem_addr, e[47:32]);
          chk("we_data", mem_wdata, e[31:0]);
        end
        dut_mem[mem_addr] = mem_wdata;
      end
      if (mem_re) begin
        chk("re_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) chk("re_addr", mem_addr, exp_rd.pop_front());
      end
      if (err_cmd) n_cmd++;
      if (err_timeout) n_tmo++;
      if (err_overrun) n_ovr++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 900000", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int gmax, input bit with_csum);
    logic [7:0] cs;
    cs = 8'h00;
    foreach (frame[i]) begin
      cs ^= frame[i];
      send_byte(frame[i]);
      if (gmax > 0) repeat ($urandom_range(gmax, 0)) @(posedge clk);
    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    if (with_csum) send_byte(cs);
`else
    if (with_csum) cs = 8'h00;
`endif
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    repeat (3) @(posedge clk);
    while ((busy || exp_tx.size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("idle_reached", t < 3000, 1);
    @(negedge clk);
    chk("busy_low", busy, 0);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    chk("err_cmd_count", n_cmd, exp_cmd);
    chk("err_timeout_count", n_tmo, exp_tmo);
    chk("err_overrun_count", n_ovr, exp_ovr);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int gmax);
    frame.delete();
    frame.push_back(8'h57); frame.push_back(a[15:8]); frame.push_back(a[7:0]);
    frame.push_back(d[31:24]); frame.push_back(d[23:16]);
    frame.push_back(d[15:8]); frame.push_back(d[7:0]);
    exp_wr.push_back({a, d});
    ref_mem[a] = d;
    exp_tx.push_back(8'h06);
    send_frame(gmax, 1'b1);
    wait_idle();
  endtask

  task automatic do_read(input logic [15:0] a, input int gmax, input bit ovr);
    logic [31:0] v;
    int t, t0;
    v = ref_read(a);
    frame.delete();
    frame.push_back(8'h52); frame.push_back(a[15:8]); frame.push_back(a[7:0]);
    exp_rd.push_back(a);
    exp_tx.push_back(v[31:24]); exp_tx.push_back(v[23:16]);
    exp_tx.push_back(v[15:8]);  exp_tx.push_back(v[7:0]);
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    exp_tx.push_back(v[31:24] ^ v[23:16] ^ v[15:8] ^ v[7:0]);
`endif
    t0 = tx_seen;
    send_frame(gmax, 1'b1);
    if (ovr) begin
      t = 0;
      while (tx_seen == t0 && t < 500) begin
        @(posedge clk);
        t++;
      end
      chk("reply_started", t < 500, 1);
      repeat (2) @(posedge clk);
      send_byte(8'hAA);
      exp_ovr++;
    end
    wait_idle();
  endtask

  task automatic do_bad(input logic [7:0] b);
    frame.delete();
    frame.push_back(b);
    exp_tx.push_back(8'h15);
    exp_cmd++;
    send_frame(0, 1'b0);
    wait_idle();
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {tx_data, tx_start, mem_addr, mem_wdata, mem_we, mem_re,
                          busy, err_timeout, err_cmd, err_overrun}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Read with a known memory word; reply bytes pinned literally.
    dut_mem[16'h0010] = 32'h12345678;
    ref_mem[16'h0010] = 32'h12345678;
    rlat = 3;
    tx_log.delete();
    do_read(16'h0010, 0, 1'b0);
    chk("read_lit_b0", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h12);
    chk("read_lit_b1", tx_log.size() > 1 ? tx_log[1] : 8'hxx, 8'h34);
    chk("read_lit_b2", tx_log.size() > 2 ? tx_log[2] : 8'hxx, 8'h56);
    chk("read_lit_b3", tx_log.size() > 3 ? tx_log[3] : 8'hxx, 8'h78);

    // Write, then confirm the stored word and the ACK literally.
    tx_log.delete();
    do_write(16'h0010, 32'hDEADBEEF, 0);
    chk("write_ack_lit", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h06);
    chk("write_mem_lit", dut_mem[16'h0010], 32'hDEADBEEF);
    chk("write_reply_len", tx_log.size(), 1);

    // Unknown command byte.
    tx_log.delete();
    do_bad(8'h41);
    chk("nak_lit", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h15);
    chk("err_cmd_lit", n_cmd, 1);

    // Partial frame then silence.
    tx_log.delete();
    frame.delete();
    frame.push_back(8'h57); frame.push_back(8'h00);
    send_frame(0, 1'b0);
    repeat (95) @(posedge clk);
    @(negedge clk);
    chk("timeout_not_early", n_tmo, 0);
    exp_tmo++;
    repeat (15) @(posedge clk);
    wait_idle();
    chk("timeout_lit", n_tmo, 1);
    chk("timeout_no_tx", tx_log.size(), 0);
    do_write(16'h0042, 32'hCAFEF00D, 0);

    // Byte arriving during the read reply.
    tx_log.delete();
    do_read(16'h0042, 0, 1'b1);
    chk("overrun_lit", n_ovr, 1);
    chk("overrun_reply_b0", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'hCA);

    // Reset in the middle of the data bytes.
    frame.delete();
    frame.push_back(8'h57); frame.push_back(8'h00);
    frame.push_back(8'h10); frame.push_back(8'hDE);
    send_frame(0, 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs", {tx_data, tx_start, mem_addr, mem_wdata, mem_we, mem_re,
                              busy, err_timeout, err_cmd, err_overrun}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (150) @(posedge clk);
    wait_idle();

    // Randomized traffic over a small address window.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(3, 0);
      rlat = $urandom_range(6, 1);
      if (kind <= 1) begin
        do_write({12'h000, 4'($urandom)}, $urandom, 20);
      end else if (kind == 2) begin
        do_read({12'h000, 4'($urandom)}, 20, 1'b0);
      end else begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        do_bad(b);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
